lane_stripe_ctrl: RTL and testbench

//  Round-robin byte-striping controller for the multi-lane TX path. Takes one
//  9-bit word stream (8 data bits + valid in bit 0) and writes it across

---
 rtl/lane_stripe_ctrl.sv | 106 ++++++++++
 tb/tb_lane_stripe_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_stripe_ctrl.sv
// Round-robin byte-striping controller: spreads one valid-tagged word stream across
// up to LANES output lanes and pads the open stripe to a lane-0 boundary on stop.
module lane_stripe_ctrl #(
    parameter int unsigned LANES   = 4,
    parameter logic [7:0]  PAD_SYM = 8'hF7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8:0]           in_data,
    output logic                 in_ready,
    input  logic [1:0]           lane_cfg,
    input  logic                 start,
    input  logic                 stop,
    input  logic [LANES-1:0]     lane_ready,
    output logic [9*LANES-1:0]   out_data,
    output logic                 busy,
    output logic [15:0]          stripe_cnt
);

    localparam int unsigned SW = $clog2(LANES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STRIPE = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [1:0]    state;
    logic [SW-1:0] sel;
    logic [SW:0]   act;
    logic [SW:0]   act_dec;
    int unsigned   cfg_lanes;
    logic          sel_last;
    logic [SW-1:0] sel_inc;
    logic          accept;
    logic          pad;
    logic          wr_en;
    logic [8:0]    wr_word;

    always_comb begin
        cfg_lanes = 1;
        case (lane_cfg)
            2'd0:    cfg_lanes = 1;
            2'd1:    cfg_lanes = 2;
            2'd2:    cfg_lanes = 4;
            default: cfg_lanes = LANES;
        endcase
        act_dec = (cfg_lanes > LANES) ? (SW+1)'(LANES) : (SW+1)'(cfg_lanes);
    end

    assign sel_last = ({1'b0, sel} == (act - 1'b1));
    assign sel_inc  = sel_last ? '0 : sel + 1'b1;

    assign in_ready = (state == STRIPE) && lane_ready[sel];
    assign busy     = (state != IDLE);

    // Lane 0 is never padded: a drain that reaches sel==0 has completed the stripe.
    assign accept  = in_ready && in_data[0];
    assign pad     = (state == DRAIN) && (sel != '0) && lane_ready[sel];
    assign wr_en   = accept || pad;
    assign wr_word = pad ? {PAD_SYM, 1'b1} : in_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sel        <= '0;
            act        <= (SW+1)'(1);
            out_data   <= '0;
            stripe_cnt <= '0;
        end else begin
            out_data <= '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                if (wr_en && (sel == SW'(k)))
                    out_data[9*k +: 9] <= wr_word;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= STRIPE;
                        act        <= act_dec;
                        sel        <= '0;
                        stripe_cnt <= '0;
                    end
                end
                STRIPE: begin
                    if (accept) begin
                        sel        <= sel_inc;
                        stripe_cnt <= stripe_cnt + 16'd1;
                    end
                    if (stop)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (sel == '0) begin
                        state <= IDLE;
                    end else if (pad) begin
                        sel <= sel_inc;
                        if (sel_last)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lane_stripe_ctrl.sv
// Directed bench for lane_stripe_ctrl (LANES=4): striping order, backpressure,
// pad/drain behaviour, lane_cfg decode and asynchronous reset.
module tb_lane_stripe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  in_data;
    logic        in_ready;
    logic [1:0]  lane_cfg;
    logic        start;
    logic        stop;
    logic [3:0]  lane_ready;
    logic [35:0] out_data;
    logic        busy;
    logic [15:0] stripe_cnt;

    int vectors = 0;
    int miscompares = 0;

    lane_stripe_ctrl #(.LANES(4), .PAD_SYM(8'hF7)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ready(in_ready),
        .lane_cfg(lane_cfg), .start(start), .stop(stop), .lane_ready(lane_ready),
        .out_data(out_data), .busy(busy), .stripe_cnt(stripe_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] lw(input int k, input logic [8:0] w);
        logic [35:0] r;
        r = '0;
        r[9*k +: 9] = w;
        return r;
    endfunction

    task automatic chk_out(input string tag, input logic [35:0] exp);
        chk(tag, 64'(out_data), 64'(exp));
    endtask

    task automatic chk_busy(input string tag, input logic exp);
        chk(tag, 64'(busy), 64'(exp));
    endtask

    localparam logic [8:0] PADW = {8'hF7, 1'b1};

    logic [8:0] w;
    logic [8:0] t5_word [7];
    int         t5_lane [7];

    initial begin
        reset = 1'b0; in_data = '0; lane_cfg = 2'd0; start = 1'b0; stop = 1'b0;
        lane_ready = 4'b1111;
        #3;
        chk_out("rst_out", '0);
        chk_busy("rst_busy", 1'b0);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_cnt", 64'(stripe_cnt), 64'(0));
        tick();
        reset = 1'b1;
        tick();

        // T2: four lanes, eight words in lane order 0..3,0..3
        lane_cfg = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk_busy("t2_busy", 1'b1);
        chk("t2_cnt0", 64'(stripe_cnt), 64'(0));
        for (int i = 0; i < 8; i++) begin
            w = {8'(8'h11 * (i + 1)), 1'b1};
            in_data = w;
            tick();
            chk_out($sformatf("t2_word%0d", i), lw(i % 4, w));
        end
        in_data = '0;
        tick();
        chk_out("t2_idle_out", '0);
        chk("t2_cnt8", 64'(stripe_cnt), 64'(8));

        // stop at a stripe boundary: one DRAIN cycle, no pads
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_busy("bnd_drain_busy", 1'b1);
        chk_out("bnd_drain_out", '0);
        tick();
        chk_busy("bnd_idle_busy", 1'b0);
        chk_out("bnd_idle_out", '0);

        // T3: five words then stop -> pads on lanes 1,2,3
        lane_cfg = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w = {8'(8'hA1 + i), 1'b1};
            in_data = w;
            tick();
            chk_out($sformatf("t3_word%0d", i), lw(i % 4, w));
        end
        in_data = '0; stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("t3_stop_out", '0);
        chk_busy("t3_stop_busy", 1'b1);
        tick();
        chk_out("t3_pad1", lw(1, PADW));
        chk_busy("t3_pad1_busy", 1'b1);
        tick();
        chk_out("t3_pad2", lw(2, PADW));
        chk_busy("t3_pad2_busy", 1'b1);
        tick();
        chk_out("t3_pad3", lw(3, PADW));
        chk_busy("t3_pad3_busy", 1'b0);
        tick();
        chk_out("t3_after", '0);
        chk("t3_cnt", 64'(stripe_cnt), 64'(5));

        // T4: lane 2 backpressure with the word held, then drain stall on lane 3
        lane_cfg = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        in_data = {8'h01, 1'b1};
        tick();
        in_data = {8'h02, 1'b1};
        tick();
        chk_out("t4_w1", lw(1, {8'h02, 1'b1}));
        lane_ready = 4'b1011;
        in_data = {8'h5A, 1'b1};
        #1;
        chk("t4_ready_lo", 64'(in_ready), 64'(0));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("t4_stall%0d", i), '0);
            chk("t4_stall_rdy", 64'(in_ready), 64'(0));
        end
        chk("t4_cnt_held", 64'(stripe_cnt), 64'(2));
        lane_ready = 4'b1111;
        #1;
        chk("t4_ready_hi", 64'(in_ready), 64'(1));
        tick();
        in_data = '0;
        chk_out("t4_release", lw(2, {8'h5A, 1'b1}));
        chk("t4_cnt", 64'(stripe_cnt), 64'(3));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        lane_ready = 4'b0111;
        tick();
        chk_out("t4_dstall0", '0);
        chk_busy("t4_dstall_busy", 1'b1);
        tick();
        chk_out("t4_dstall1", '0);
        lane_ready = 4'b1111;
        tick();
        chk_out("t4_pad3", lw(3, PADW));
        chk_busy("t4_end_busy", 1'b0);

        // T5: two lanes, invalid words in the stream are skipped
        t5_word = '{9'h031, 9'h130, 9'h051, 9'h071, 9'h080, 9'h090, 9'h0B1};
        t5_lane = '{0, -1, 1, 0, -1, -1, 1};
        lane_cfg = 2'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_data = t5_word[i];
            tick();
            chk_out($sformatf("t5_step%0d", i),
                    (t5_lane[i] < 0) ? 36'd0 : lw(t5_lane[i], t5_word[i]));
        end
        in_data = '0;
        chk("t5_cnt", 64'(stripe_cnt), 64'(4));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("t5_nopad", '0);
        tick();
        chk_busy("t5_idle", 1'b0);
        chk_out("t5_nopad2", '0);

        // T6: stop together with the word that completes the stripe
        lane_cfg = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = {8'(8'hC0 + i), 1'b1};
            tick();
        end
        in_data = {8'hC3, 1'b1}; stop = 1'b1;
        tick();
        in_data = '0; stop = 1'b0;
        chk_out("t6_word3", lw(3, {8'hC3, 1'b1}));
        chk_busy("t6_drain", 1'b1);
        tick();
        chk_out("t6_nopad", '0);
        chk_busy("t6_idle", 1'b0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk_busy("t6_ss_busy", 1'b1);
        chk("t6_ss_ready", 64'(in_ready), 64'(1));
        tick();
        chk_busy("t6_ss_stay", 1'b1);
        chk("t6_ss_cnt", 64'(stripe_cnt), 64'(0));

        // T1: asynchronous reset in the middle of a stripe
        in_data = {8'hD0, 1'b1};
        tick();
        in_data = {8'hD1, 1'b1};
        tick();
        chk_out("t1_pre", lw(1, {8'hD1, 1'b1}));
        #2 reset = 1'b0;
        #1;
        chk_out("t1_out", '0);
        chk_busy("t1_busy", 1'b0);
        chk("t1_ready", 64'(in_ready), 64'(0));
        chk("t1_cnt", 64'(stripe_cnt), 64'(0));
        tick();
        #2 reset = 1'b1;
        in_data = '0;
        tick();
        chk_out("t1_nopad", '0);
        chk_busy("t1_busy_after", 1'b0);

        // lane_cfg=3 uses all LANES and restarts from lane 0
        lane_cfg = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w = {8'(8'hE0 + i), 1'b1};
            in_data = w;
            tick();
            chk_out($sformatf("cfg3_word%0d", i), lw(i % 4, w));
        end
        in_data = '0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        chk_out("cfg3_pad1", lw(1, PADW));
        tick();
        tick();
        chk_out("cfg3_pad3", lw(3, PADW));
        chk_busy("cfg3_idle", 1'b0);

        // lane_cfg=0: single lane, stop never pads
        lane_cfg = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w = {8'(8'h60 + i), 1'b1};
            in_data = w;
            tick();
            chk_out($sformatf("cfg0_word%0d", i), lw(0, w));
        end
        in_data = '0; stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("cfg0_stop", '0);
        tick();
        chk_out("cfg0_nopad", '0);
        chk_busy("cfg0_idle", 1'b0);
        chk("cfg0_cnt", 64'(stripe_cnt), 64'(2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
